// File: rtl/amm_write_driver.sv
// Avalon-MM write burst generator fed from a small command FIFO.
// Data and byteenable follow the same pattern/LFSR rules as the read-compare path.
module amm_write_driver #(
  parameter int unsigned AMM_DATA_W  = 64,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned AMM_BURST_W = 11,
  parameter int unsigned CMD_FIFO_AW = 2,
  parameter string       ADDR_TYPE   = "BYTE",
  localparam int unsigned DATA_B_W   = AMM_DATA_W / 8,
  localparam int unsigned ADDR_B_W   = $clog2(DATA_B_W)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_test_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [ADDR_W-1:0]      cmd_start_addr_i,
  input  logic [AMM_BURST_W-2:0] cmd_words_count_i,
  input  logic [ADDR_B_W-1:0]    cmd_start_off_i,
  input  logic [ADDR_B_W-1:0]    cmd_end_off_i,
  input  logic [7:0]             cmd_data_ptrn_i,
  input  logic                   cmd_data_mode_i,
  output logic [ADDR_W-1:0]      amm_address_o,
  output logic                   amm_write_o,
  output logic [AMM_BURST_W-1:0] amm_burstcount_o,
  output logic [AMM_DATA_W-1:0]  amm_writedata_o,
  output logic [DATA_B_W-1:0]    amm_byteenable_o,
  input  logic                   amm_waitrequest_i,
  output logic                   burst_done_o,
  output logic                   busy_o
);

  localparam int unsigned FIFO_DEPTH = 2 ** CMD_FIFO_AW;
  localparam logic [ADDR_W-1:0] ADDR_MASK = (ADDR_TYPE == "BYTE") ?
    {{(ADDR_W-ADDR_B_W){1'b1}}, {ADDR_B_W{1'b0}}} : {ADDR_W{1'b1}};

  typedef enum logic [1:0] {IDLE, LOAD, BURST} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]      addr;
    logic [AMM_BURST_W-2:0] words;
    logic [ADDR_B_W-1:0]    soff;
    logic [ADDR_B_W-1:0]    eoff;
    logic [7:0]             ptrn;
    logic                   mode;
  } cmd_t;

  state_t                 state_q, state_d;
  cmd_t                   fifo_mem [FIFO_DEPTH];
  cmd_t                   head;
  logic [CMD_FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [CMD_FIFO_AW:0]   count;
  logic                   fifo_full, fifo_empty, push, pop;

  logic [ADDR_W-1:0]      addr_q;
  logic [AMM_BURST_W-2:0] words_q, beat_q;
  logic [ADDR_B_W-1:0]    soff_q, eoff_q;
  logic [7:0]             ptrn_q;
  logic                   mode_q, done_q;
  logic                   in_burst, beat_acc, last_beat;
  logic [DATA_B_W-1:0]    first_mask, last_mask;

  assign fifo_full  = count[CMD_FIFO_AW];
  assign fifo_empty = (count == '0);
  assign pop        = (state_q == LOAD) && !fifo_empty && !start_test_i;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push       = cmd_valid_i && !start_test_i && (!fifo_full || pop);
  assign head       = fifo_mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{addr: cmd_start_addr_i, words: cmd_words_count_i,
                            soff: cmd_start_off_i, eoff: cmd_end_off_i,
                            ptrn: cmd_data_ptrn_i, mode: cmd_data_mode_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (start_test_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign in_burst  = (state_q == BURST);
  assign beat_acc  = in_burst && !amm_waitrequest_i;
  assign last_beat = (beat_q == words_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!fifo_empty) state_d = LOAD;
      LOAD:  state_d = pop ? BURST : IDLE;
      BURST: if (beat_acc && last_beat) state_d = (fifo_empty || start_test_i) ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      words_q <= '0;
      soff_q  <= '0;
      eoff_q  <= '0;
      ptrn_q  <= '0;
      mode_q  <= 1'b0;
      beat_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= beat_acc && last_beat;
      if (pop) begin
        addr_q  <= head.addr & ADDR_MASK;
        words_q <= head.words;
        soff_q  <= head.soff;
        eoff_q  <= head.eoff;
        ptrn_q  <= head.ptrn;
        mode_q  <= head.mode;
        beat_q  <= '0;
      end else if (beat_acc) begin
        beat_q <= beat_q + 1'b1;
        if (mode_q) ptrn_q <= {ptrn_q[6:0], ptrn_q[6] ^ ptrn_q[1] ^ ptrn_q[0]};
      end
    end
  end

  // ~eoff_q equals (DATA_B_W-1)-eoff_q since DATA_B_W is a power of two.
  assign first_mask = {DATA_B_W{1'b1}} << soff_q;
  assign last_mask  = {DATA_B_W{1'b1}} >> (~eoff_q);

  always_comb begin
    amm_write_o      = in_burst;
    amm_address_o    = '0;
    amm_burstcount_o = '0;
    amm_writedata_o  = '0;
    amm_byteenable_o = '0;
    if (in_burst) begin
      amm_address_o    = addr_q;
      amm_burstcount_o = AMM_BURST_W'(words_q) + AMM_BURST_W'(1);
      amm_writedata_o  = {DATA_B_W{ptrn_q}};
      amm_byteenable_o = ((beat_q == '0) ? first_mask : {DATA_B_W{1'b1}}) &
                         (last_beat ? last_mask : {DATA_B_W{1'b1}});
    end
  end

  assign cmd_ready_o  = !fifo_full;
  assign burst_done_o = done_q;
  assign busy_o       = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_amm_write_driver.sv
// Directed self-checking bench for amm_write_driver (64-bit data, byte addressing).
module tb_amm_write_driver;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_test_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [31:0] cmd_start_addr_i = '0;
  logic [9:0]  cmd_words_count_i = '0;
  logic [2:0]  cmd_start_off_i = '0;
  logic [2:0]  cmd_end_off_i = '0;
  logic [7:0]  cmd_data_ptrn_i = '0;
  logic        cmd_data_mode_i = 1'b0;
  logic [31:0] amm_address_o;
  logic        amm_write_o;
  logic [10:0] amm_burstcount_o;
  logic [63:0] amm_writedata_o;
  logic [7:0]  amm_byteenable_o;
  logic        amm_waitrequest_i = 1'b0;
  logic        burst_done_o;
  logic        busy_o;

  int n_pass = 0;
  int n_total = 0;

  amm_write_driver #(
    .AMM_DATA_W(64), .ADDR_W(32), .AMM_BURST_W(11), .CMD_FIFO_AW(2), .ADDR_TYPE("BYTE")
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_test_i(start_test_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_start_addr_i(cmd_start_addr_i), .cmd_words_count_i(cmd_words_count_i),
    .cmd_start_off_i(cmd_start_off_i), .cmd_end_off_i(cmd_end_off_i),
    .cmd_data_ptrn_i(cmd_data_ptrn_i), .cmd_data_mode_i(cmd_data_mode_i),
    .amm_address_o(amm_address_o), .amm_write_o(amm_write_o),
    .amm_burstcount_o(amm_burstcount_o), .amm_writedata_o(amm_writedata_o),
    .amm_byteenable_o(amm_byteenable_o), .amm_waitrequest_i(amm_waitrequest_i),
    .burst_done_o(burst_done_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Presents one command for exactly one clock edge; returns 1 time unit after that edge.
  task automatic push_cmd(input logic [31:0] addr, input logic [9:0] cnt, input logic [2:0] soff,
                          input logic [2:0] eoff, input logic [7:0] ptrn, input logic mode);
    cmd_valid_i       = 1'b1;
    cmd_start_addr_i  = addr;
    cmd_words_count_i = cnt;
    cmd_start_off_i   = soff;
    cmd_end_off_i     = eoff;
    cmd_data_ptrn_i   = ptrn;
    cmd_data_mode_i   = mode;
    step();
    cmd_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_total++; if (amm_write_o !== 1'b0) $display("FAIL rst_write got %0b exp 0", amm_write_o); else n_pass++;
    n_total++; if (cmd_ready_o !== 1'b1) $display("FAIL rst_ready got %0b exp 1", cmd_ready_o); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL rst_busy got %0b exp 0", busy_o); else n_pass++;
    n_total++; if (burst_done_o !== 1'b0) $display("FAIL rst_done got %0b exp 0", burst_done_o); else n_pass++;
    n_total++; if ({amm_address_o, amm_burstcount_o, amm_byteenable_o, amm_writedata_o} !== '0)
      $display("FAIL rst_outs got addr %h bc %0d be %h data %h exp all 0", amm_address_o, amm_burstcount_o, amm_byteenable_o, amm_writedata_o);
    else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b0;
    step();
    n_total++; if (busy_o !== 1'b0 || amm_write_o !== 1'b0) $display("FAIL post_rst_idle got busy %0b write %0b exp 0 0", busy_o, amm_write_o); else n_pass++;
  endtask

  task automatic test_single();
    push_cmd(32'h100, 10'd0, 3'd2, 3'd5, 8'hA5, 1'b0);
    n_total++; if (amm_write_o !== 1'b0) $display("FAIL t1_lat0 got %0b exp 0", amm_write_o); else n_pass++;
    step();
    n_total++; if (amm_write_o !== 1'b0) $display("FAIL t1_lat1 got %0b exp 0", amm_write_o); else n_pass++;
    step();
    n_total++; if (amm_write_o !== 1'b1) $display("FAIL t1_write got %0b exp 1", amm_write_o); else n_pass++;
    n_total++; if (amm_address_o !== 32'h100) $display("FAIL t1_addr got %h exp 00000100", amm_address_o); else n_pass++;
    n_total++; if (amm_burstcount_o !== 11'd1) $display("FAIL t1_bc got %0d exp 1", amm_burstcount_o); else n_pass++;
    n_total++; if (amm_byteenable_o !== 8'h3C) $display("FAIL t1_be got %h exp 3c", amm_byteenable_o); else n_pass++;
    n_total++; if (amm_writedata_o !== 64'hA5A5A5A5A5A5A5A5) $display("FAIL t1_data got %h exp a5a5a5a5a5a5a5a5", amm_writedata_o); else n_pass++;
    step();
    n_total++; if (amm_write_o !== 1'b0 || burst_done_o !== 1'b1) $display("FAIL t1_done got write %0b done %0b exp 0 1", amm_write_o, burst_done_o); else n_pass++;
    step();
    n_total++; if (burst_done_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL t1_after got done %0b busy %0b exp 0 0", burst_done_o, busy_o); else n_pass++;
  endtask

  task automatic test_lfsr();
    logic [7:0] exp_b [3] = '{8'h01, 8'h03, 8'h06};
    push_cmd(32'h200, 10'd2, 3'd0, 3'd7, 8'h01, 1'b1);
    step();
    step();
    n_total++; if (amm_address_o !== 32'h200) $display("FAIL t2_addr got %h exp 00000200", amm_address_o); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (amm_write_o !== 1'b1 || amm_writedata_o !== {8{exp_b[i]}})
        $display("FAIL t2_beat%0d got write %0b data %h exp 1 %h", i, amm_write_o, amm_writedata_o, {8{exp_b[i]}});
      else n_pass++;
      n_total++; if (amm_byteenable_o !== 8'hFF || amm_burstcount_o !== 11'd3)
        $display("FAIL t2_be_bc%0d got be %h bc %0d exp ff 3", i, amm_byteenable_o, amm_burstcount_o);
      else n_pass++;
      step();
    end
    n_total++; if (burst_done_o !== 1'b1 || amm_write_o !== 1'b0) $display("FAIL t2_done got done %0b write %0b exp 1 0", burst_done_o, amm_write_o); else n_pass++;
    step();
  endtask

  task automatic test_edge_masks();
    logic [7:0] exp_be [3] = '{8'hF8, 8'hFF, 8'h1F};
    push_cmd(32'h1007, 10'd2, 3'd3, 3'd4, 8'h5C, 1'b0);
    step();
    step();
    n_total++; if (amm_address_o !== 32'h1000) $display("FAIL em_addr got %h exp 00001000", amm_address_o); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (amm_byteenable_o !== exp_be[i] || amm_writedata_o !== {8{8'h5C}})
        $display("FAIL em_beat%0d got be %h data %h exp %h %h", i, amm_byteenable_o, amm_writedata_o, exp_be[i], {8{8'h5C}});
      else n_pass++;
      step();
    end
    n_total++; if (burst_done_o !== 1'b1) $display("FAIL em_done got %0b exp 1", burst_done_o); else n_pass++;
    step();
  endtask

  task automatic test_waitrequest();
    push_cmd(32'h300, 10'd2, 3'd0, 3'd7, 8'h01, 1'b1);
    step();
    step();
    n_total++; if (amm_writedata_o !== {8{8'h01}}) $display("FAIL t3_beat0 got %h exp %h", amm_writedata_o, {8{8'h01}}); else n_pass++;
    step();
    amm_waitrequest_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++; if (amm_write_o !== 1'b1 || amm_writedata_o !== {8{8'h03}} || amm_burstcount_o !== 11'd3 || amm_address_o !== 32'h300)
        $display("FAIL t3_hold%0d got write %0b data %h bc %0d addr %h exp 1 %h 3 00000300", i, amm_write_o, amm_writedata_o, amm_burstcount_o, amm_address_o, {8{8'h03}});
      else n_pass++;
    end
    amm_waitrequest_i = 1'b0;
    step();
    n_total++; if (amm_write_o !== 1'b1 || amm_writedata_o !== {8{8'h06}})
      $display("FAIL t3_beat2 got write %0b data %h exp 1 %h", amm_write_o, amm_writedata_o, {8{8'h06}});
    else n_pass++;
    step();
    n_total++; if (amm_write_o !== 1'b0 || burst_done_o !== 1'b1) $display("FAIL t3_done got write %0b done %0b exp 0 1", amm_write_o, burst_done_o); else n_pass++;
    step();
  endtask

  task automatic test_fifo_full();
    int addrs[$];
    int cycs[$];
    amm_waitrequest_i = 1'b1;
    for (int k = 1; k <= 5; k++) push_cmd(32'(k * 32'h40), 10'd0, 3'd0, 3'd7, 8'(k), 1'b0);
    n_total++; if (cmd_ready_o !== 1'b0) $display("FAIL t4_ready got %0b exp 0", cmd_ready_o); else n_pass++;
    n_total++; if (amm_write_o !== 1'b1 || amm_address_o !== 32'h40) $display("FAIL t4_inflight got write %0b addr %h exp 1 00000040", amm_write_o, amm_address_o); else n_pass++;
    push_cmd(32'h180, 10'd0, 3'd0, 3'd7, 8'h06, 1'b0);
    amm_waitrequest_i = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (amm_write_o) begin
        addrs.push_back(int'(amm_address_o));
        cycs.push_back(c);
      end
      step();
    end
    n_total++; if (addrs.size() != 5) $display("FAIL t4_count got %0d exp 5", addrs.size()); else n_pass++;
    for (int k = 0; k < addrs.size() && k < 5; k++) begin
      n_total++; if (addrs[k] != (k + 1) * 'h40) $display("FAIL t4_order%0d got %h exp %h", k, addrs[k], (k + 1) * 'h40); else n_pass++;
      if (k > 0) begin
        n_total++; if (cycs[k] - cycs[k-1] != 2) $display("FAIL t4_gap%0d got %0d exp 2", k, cycs[k] - cycs[k-1]); else n_pass++;
      end
    end
    n_total++; if (busy_o !== 1'b0 || cmd_ready_o !== 1'b1) $display("FAIL t4_end got busy %0b ready %0b exp 0 1", busy_o, cmd_ready_o); else n_pass++;
  endtask

  task automatic test_start_test();
    int extra = 0;
    push_cmd(32'h400, 10'd3, 3'd0, 3'd7, 8'h11, 1'b0);
    push_cmd(32'h500, 10'd0, 3'd0, 3'd7, 8'h22, 1'b0);
    push_cmd(32'h600, 10'd0, 3'd0, 3'd7, 8'h33, 1'b0);
    n_total++; if (amm_write_o !== 1'b1 || amm_address_o !== 32'h400) $display("FAIL t5_beat0 got write %0b addr %h exp 1 00000400", amm_write_o, amm_address_o); else n_pass++;
    step();
    start_test_i = 1'b1;
    step();
    start_test_i = 1'b0;
    n_total++; if (amm_write_o !== 1'b1 || busy_o !== 1'b1) $display("FAIL t5_beat2 got write %0b busy %0b exp 1 1", amm_write_o, busy_o); else n_pass++;
    step();
    n_total++; if (amm_write_o !== 1'b1 || amm_burstcount_o !== 11'd4) $display("FAIL t5_beat3 got write %0b bc %0d exp 1 4", amm_write_o, amm_burstcount_o); else n_pass++;
    step();
    n_total++; if (amm_write_o !== 1'b0 || burst_done_o !== 1'b1 || busy_o !== 1'b0)
      $display("FAIL t5_done got write %0b done %0b busy %0b exp 0 1 0", amm_write_o, burst_done_o, busy_o);
    else n_pass++;
    for (int c = 0; c < 10; c++) begin
      if (amm_write_o) extra++;
      step();
    end
    n_total++; if (extra != 0) $display("FAIL t5_flushed got %0d extra beats exp 0", extra); else n_pass++;
  endtask

  task automatic test_reset_mid();
    push_cmd(32'h700, 10'd7, 3'd0, 3'd7, 8'h44, 1'b0);
    step();
    step();
    n_total++; if (amm_write_o !== 1'b1) $display("FAIL t6_started got %0b exp 1", amm_write_o); else n_pass++;
    #2;
    rst_i = 1'b1;
    #1;
    n_total++; if (amm_write_o !== 1'b0 || busy_o !== 1'b0 || amm_address_o !== 32'h0)
      $display("FAIL t6_async got write %0b busy %0b addr %h exp 0 0 00000000", amm_write_o, busy_o, amm_address_o);
    else n_pass++;
    step();
    #2;
    rst_i = 1'b0;
    step();
    push_cmd(32'h800, 10'd0, 3'd0, 3'd7, 8'h55, 1'b0);
    step();
    n_total++; if (amm_write_o !== 1'b0) $display("FAIL t6_lat1 got %0b exp 0", amm_write_o); else n_pass++;
    step();
    n_total++; if (amm_write_o !== 1'b1 || amm_address_o !== 32'h800) $display("FAIL t6_restart got write %0b addr %h exp 1 00000800", amm_write_o, amm_address_o); else n_pass++;
    step();
    n_total++; if (burst_done_o !== 1'b1) $display("FAIL t6_done got %0b exp 1", burst_done_o); else n_pass++;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_lfsr();
    test_edge_masks();
    test_waitrequest();
    test_fifo_full();
    test_start_test();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
